// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - shared types and helpers for the micro-sequencer
// Purpose: write-select encoding, reserved next-address codes and
//          control-word field slicing shared by the sequencer files.
// Ports:   none (package).
package micro_pkg;

  // Write-select encoding; 2'b11 is accepted on the bus but ignored.
  typedef enum logic [1:0] {
    WS_STORE = 2'b00,
    WS_DISP0 = 2'b01,
    WS_DISP1 = 2'b10
  } wr_sel_e;

  // Widest control word the slice helpers handle (CTRL_W + ADDR_W).
  localparam int WORD_MAX_W = 64;

  // Reserved next-address codes: all-ones dispatches through table 0,
  // all-ones-minus-one through table 1.
  function automatic int next_disp0(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  function automatic int next_disp1(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction

  // Word layout is {ctrl, next}; callers truncate to the real field width.
  function automatic logic [WORD_MAX_W-1:0] word_next(input logic [WORD_MAX_W-1:0] w,
                                                      input int addr_w);
    return w & ((64'd1 << addr_w) - 64'd1);
  endfunction

  function automatic logic [WORD_MAX_W-1:0] word_ctrl(input logic [WORD_MAX_W-1:0] w,
                                                      input int addr_w);
    return w >> addr_w;
  endfunction

endpackage

// File: rtl/micro_dispatch_table.sv
// rtl/micro_dispatch_table.sv - opcode dispatch table for the micro-sequencer
// Purpose: 2**OP_W entries of {valid, target}; synchronous write,
//          combinational read, valid bits cleared by reset.
// Ports:   clk_i, reset_i      clock, synchronous active-high reset
//          wr_en_i, wr_idx_i   write strobe and entry index
//          wr_data_i           {valid, target}
//          rd_idx_i            read index
//          rd_valid_o          valid bit of the addressed entry
//          rd_target_o         target of the addressed entry
module micro_dispatch_table #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [OP_W-1:0]   wr_idx_i,
  input  logic [ADDR_W:0]   wr_data_i,
  input  logic [OP_W-1:0]   rd_idx_i,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] rd_target_o
);

  localparam int ENTRIES = 2 ** OP_W;

  logic              valid_q  [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  // Targets need no reset: they are only consumed when the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i]  <= wr_data_i[ADDR_W];
      target_q[wr_idx_i] <= wr_data_i[ADDR_W-1:0];
    end
  end

  // Read sees pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - writable-control-store micro-sequencer
// Purpose: registered micro-PC stepping through a writable control store,
//          with two opcode dispatch tables, stall hold and an illegal
//          dispatch trap.
// Ports:   clk, reset     clock, synchronous active-high reset
//          stall          hold the micro-PC this cycle
//          op_idx         dispatch index from decode
//          wr_en, wr_sel  write strobe and target (store / disp0 / disp1)
//          wr_adr         write address (dispatch uses low OP_W bits)
//          wr_data        store word or {valid, target}
//          ctrl           control field of store[upc]
//          upc            current micro-PC
//          trap           one-cycle pulse when an invalid dispatch lands
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int CTRL_W    = 15,
  parameter int OP_W      = 4,
  parameter int RESET_ADR = 0,
  parameter int TRAP_ADR  = 2 ** ADDR_W - 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [OP_W-1:0]          op_idx,
  input  logic                     wr_en,
  input  logic [1:0]               wr_sel,
  input  logic [ADDR_W-1:0]        wr_adr,
  input  logic [CTRL_W+ADDR_W-1:0] wr_data,
  output logic [CTRL_W-1:0]        ctrl,
  output logic [ADDR_W-1:0]        upc,
  output logic                     trap
);

  localparam int WORD_W = CTRL_W + ADDR_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] NEXT_DISP0 = ADDR_W'(next_disp0(ADDR_W));
  localparam logic [ADDR_W-1:0] NEXT_DISP1 = ADDR_W'(next_disp1(ADDR_W));
  localparam logic [ADDR_W-1:0] RESET_UPC  = ADDR_W'(RESET_ADR);
  localparam logic [ADDR_W-1:0] TRAP_UPC   = ADDR_W'(TRAP_ADR);

  logic [WORD_W-1:0] store_q [DEPTH];
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic              trap_q, trap_d;

  logic [WORD_W-1:0] cur_word;
  logic [ADDR_W-1:0] cur_next;

  logic              d0_valid, d1_valid;
  logic [ADDR_W-1:0] d0_target, d1_target;

  logic              d0_wr_en, d1_wr_en;

  // Control store: whole array cleared on reset so next=0 parks on RESET_ADR.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else if (wr_en && (wr_sel == WS_STORE)) begin
      store_q[wr_adr] <= wr_data;
    end
  end

  assign d0_wr_en = wr_en && (wr_sel == WS_DISP0);
  assign d1_wr_en = wr_en && (wr_sel == WS_DISP1);

  micro_dispatch_table #(
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_disp0 (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (d0_wr_en),
    .wr_idx_i    (wr_adr[OP_W-1:0]),
    .wr_data_i   (wr_data[ADDR_W:0]),
    .rd_idx_i    (op_idx),
    .rd_valid_o  (d0_valid),
    .rd_target_o (d0_target)
  );

  micro_dispatch_table #(
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_disp1 (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (d1_wr_en),
    .wr_idx_i    (wr_adr[OP_W-1:0]),
    .wr_data_i   (wr_data[ADDR_W:0]),
    .rd_idx_i    (op_idx),
    .rd_valid_o  (d1_valid),
    .rd_target_o (d1_target)
  );

  // Combinational read from the registered uPC keeps ROM-equivalent timing.
  assign cur_word = store_q[upc_q];
  assign cur_next = ADDR_W'(word_next(WORD_MAX_W'(cur_word), ADDR_W));
  assign ctrl     = CTRL_W'(word_ctrl(WORD_MAX_W'(cur_word), ADDR_W));

  always_comb begin
    upc_d  = cur_next;
    trap_d = 1'b0;
    if (cur_next == NEXT_DISP0) begin
      if (d0_valid) begin
        upc_d = d0_target;
      end else begin
        upc_d  = TRAP_UPC;
        trap_d = 1'b1;
      end
    end else if (cur_next == NEXT_DISP1) begin
      if (d1_valid) begin
        upc_d = d1_target;
      end else begin
        upc_d  = TRAP_UPC;
        trap_d = 1'b1;
      end
    end
  end

  // trap is registered alongside upc so it pulses in the cycle TRAP_ADR appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q  <= RESET_UPC;
      trap_q <= 1'b0;
    end else if (stall) begin
      trap_q <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      trap_q <= trap_d;
    end
  end

  assign upc  = upc_q;
  assign trap = trap_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [3:0]  op_idx;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [4:0]  wr_adr;
  logic [19:0] wr_data;
  logic [14:0] ctrl;
  logic [4:0]  upc;
  logic        trap;

  int tests_run = 0;
  int tests_failed = 0;

  micro_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .op_idx  (op_idx),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_adr  (wr_adr),
    .wr_data (wr_data),
    .ctrl    (ctrl),
    .upc     (upc),
    .trap    (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [14:0] c, input logic [4:0] n);
    return {c, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [4:0] adr, input logic [19:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_adr  = adr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; op_idx = '0;
    wr_en = 1'b0; wr_sel = '0; wr_adr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_upc", 32'(upc), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    reset = 1'b0;

    // 1: two-word loop
    wr(2'b00, 5'd0, mk(15'h1234, 5'd1));
    wr(2'b00, 5'd1, mk(15'h0000, 5'd0));
    stall = 1'b0;
    chk("t1_upc0", 32'(upc), 32'd0);
    chk("t1_ctrl0", 32'(ctrl), 32'h1234);
    tick();
    chk("t1_upc1", 32'(upc), 32'd1);
    chk("t1_ctrl1", 32'(ctrl), 32'h0000);
    tick();
    chk("t1_upc2", 32'(upc), 32'd0);
    chk("t1_ctrl2", 32'(ctrl), 32'h1234);
    tick();
    chk("t1_upc3", 32'(upc), 32'd1);
    chk("t1_ctrl3", 32'(ctrl), 32'h0000);
    chk("t1_trap", 32'(trap), 32'd0);

    // 2: program load while stalled at upc=1, then dispatch through both tables
    stall = 1'b1;
    wr(2'b00, 5'd1,  mk(15'h0000, 5'd31));
    wr(2'b01, 5'd4,  20'h26);
    wr(2'b10, 5'd2,  20'h28);
    wr(2'b00, 5'd6,  mk(15'h0066, 5'd30));
    wr(2'b00, 5'd8,  mk(15'h0088, 5'd31));
    wr(2'b00, 5'd29, mk(15'h1D1D, 5'd1));
    wr(2'b00, 5'd3,  mk(15'h0333, 5'd31));
    wr(2'b01, 5'd3,  20'h23);
    chk("t2_hold_upc", 32'(upc), 32'd1);
    op_idx = 4'd4;
    stall  = 1'b0;
    tick();
    chk("t2_d0_upc", 32'(upc), 32'd6);
    chk("t2_d0_ctrl", 32'(ctrl), 32'h0066);
    op_idx = 4'd2;
    tick();
    chk("t2_d1_upc", 32'(upc), 32'd8);
    chk("t2_d1_ctrl", 32'(ctrl), 32'h0088);
    chk("t2_trap", 32'(trap), 32'd0);

    // 3: invalid dispatch traps for exactly one cycle
    op_idx = 4'd9;
    tick();
    chk("t3_upc", 32'(upc), 32'd29);
    chk("t3_trap", 32'(trap), 32'd1);
    chk("t3_ctrl", 32'(ctrl), 32'h1D1D);
    op_idx = 4'd4;
    tick();
    chk("t3_upc_after", 32'(upc), 32'd1);
    chk("t3_trap_after", 32'(trap), 32'd0);
    tick();
    chk("t3_back_to_6", 32'(upc), 32'd6);

    // 4: stall at upc=6 whose DISP1 entry for op_idx=5 is invalid
    stall  = 1'b1;
    op_idx = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_upc", 32'(upc), 32'd6);
      chk("t4_stall_ctrl", 32'(ctrl), 32'h0066);
      chk("t4_stall_trap", 32'(trap), 32'd0);
    end
    stall  = 1'b0;
    op_idx = 4'd2;
    tick();
    chk("t4_release_upc", 32'(upc), 32'd8);

    // 5: write hazards on the store word and on a dispatch entry
    op_idx = 4'd3;
    tick();
    chk("t5_upc3", 32'(upc), 32'd3);
    stall   = 1'b1;
    wr_en   = 1'b1;
    wr_sel  = 2'b00;
    wr_adr  = 5'd3;
    wr_data = mk(15'h7FFF, 5'd31);
    chk("t5_ctrl_old", 32'(ctrl), 32'h0333);
    tick();
    wr_en = 1'b0;
    chk("t5_ctrl_new", 32'(ctrl), 32'h7FFF);
    chk("t5_upc_held", 32'(upc), 32'd3);
    stall   = 1'b0;
    wr_en   = 1'b1;
    wr_sel  = 2'b01;
    wr_adr  = 5'd3;
    wr_data = 20'h26;
    tick();
    wr_en = 1'b0;
    chk("t5_old_target", 32'(upc), 32'd3);
    tick();
    chk("t5_new_target", 32'(upc), 32'd6);
    chk("t5_ctrl6", 32'(ctrl), 32'h0066);

    // 6: reset mid-sequence with a concurrent write
    op_idx  = 4'd2;
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_sel  = 2'b00;
    wr_adr  = 5'd0;
    wr_data = mk(15'h7777, 5'd5);
    tick();
    chk("t6_rst_upc", 32'(upc), 32'd0);
    chk("t6_rst_ctrl", 32'(ctrl), 32'd0);
    chk("t6_rst_trap", 32'(trap), 32'd0);
    reset = 1'b0;
    wr_en = 1'b0;
    stall = 1'b1;
    tick();
    chk("t6_write_dropped", 32'(ctrl), 32'd0);
    wr(2'b00, 5'd0, mk(15'h0ABC, 5'd31));
    op_idx = 4'd4;
    stall  = 1'b0;
    chk("t6_ctrl_loaded", 32'(ctrl), 32'h0ABC);
    tick();
    chk("t6_trap_upc", 32'(upc), 32'd29);
    chk("t6_trap", 32'(trap), 32'd1);
    chk("t6_trap_ctrl", 32'(ctrl), 32'd0);
    tick();
    chk("t6_after_upc", 32'(upc), 32'd0);
    chk("t6_after_trap", 32'(trap), 32'd0);

    // wr_sel=11 is ignored
    stall = 1'b1;
    wr(2'b11, 5'd0, mk(15'h1111, 5'd1));
    chk("ws11_ctrl", 32'(ctrl), 32'h0ABC);
    chk("ws11_upc", 32'(upc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Parametrised microprogrammed sequencer for the multicycle control unit. It generalises the fixed 32x20 control ROM into a writable control store with a registered micro-PC (uPC), two opcode dispatch tables, stall hold and an illegal-dispatch trap. It sits between instruction decode (which supplies op_idx) and the datapath (which consumes ctrl).

Parameters:
ADDR_W, 5, uPC / control-store address width (depth = 2**ADDR_W)
CTRL_W, 15, control-field width (word bits above the next-address field)
OP_W, 4, dispatch index width (2**OP_W entries per table)
RESET_ADR, 0, uPC value after reset (Fetch)
TRAP_ADR, 2**ADDR_W-3, uPC target on an invalid dispatch

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold the uPC this cycle (memory not ready)
op_idx  in  OP_W  dispatch index from decode
wr_en  in  1  table/store write strobe
wr_sel  in  2  00 control store, 01 dispatch0, 10 dispatch1, 11 ignored
wr_adr  in  ADDR_W  write address (dispatch tables use the low OP_W bits)
wr_data  in  CTRL_W+ADDR_W  store word, or {valid, target} in bits [ADDR_W:0] for dispatch
ctrl  out  CTRL_W  control field of store[upc]
upc  out  ADDR_W  current micro-PC
trap  out  1  one-cycle pulse, invalid dispatch taken

Behaviour:
- Word layout: {ctrl[CTRL_W-1:0], next[ADDR_W-1:0]}.
- ctrl is a combinational read of store[upc] from the registered uPC. Zero added latency, matching the existing ROM timing.
- Reserved next codes: all-ones = DISP0, all-ones-1 = DISP1. Any other value is a direct target.
- Next uPC, evaluated each cycle when stall=0:
  - direct target -> next
  - DISP0/DISP1 -> target of dispatchN[op_idx] if its valid bit is 1
  - DISP0/DISP1 with valid bit 0 -> TRAP_ADR, and trap=1 on the following cycle
- stall=1: uPC holds, trap=0, no dispatch is evaluated, and ctrl stays stable unless the held word is rewritten.
- Writes take effect at the clock edge. A same-cycle read returns the old contents.
  - Writing store[upc] changes ctrl from the next cycle.
  - Writing a dispatch entry that is used in the same cycle: the old entry is used.
  - Writes are accepted regardless of stall.
- Reset (synchronous, wins over stall and wr_en):
  - upc=RESET_ADR, trap=0
  - every store word cleared to 0 (ctrl=0; next=0 loops on RESET_ADR)
  - all dispatch valid bits cleared
- Reset mid-program aborts the sequence with no partial state. Software must reload the tables after reset.
- trap is registered: asserted exactly one cycle, the cycle in which upc==TRAP_ADR first appears. Back-to-back invalid dispatches produce consecutive pulses.
- Targets equal to the reserved codes are illegal contents. Behaviour for them is as decoded (treated as dispatch).

Decomposition:
- Package micro_pkg holds:
  - localparams NEXT_DISP0 and NEXT_DISP1 as functions of ADDR_W
  - wr_sel enum {WS_STORE, WS_DISP0, WS_DISP1}
  - field-slice helpers for ctrl/next
- Sub-module micro_dispatch_table, instanced twice: a 2**OP_W x (ADDR_W+1) register array with a synchronous write port, a combinational read port, and valid bits cleared by reset.

Test Plan:
1. Reset, then load store[0]={ctrl=15'h1234,next=1} and store[1]={ctrl=15'h0,next=0}; run 4 cycles -> upc 0,1,0,1; ctrl 1234,0000,1234,0000; trap=0.
2. store[1].next=31, dispatch0[4]={1,6}, op_idx=4 -> upc goes 1->6. Then dispatch1[2]={1,8} with next=30 and op_idx=2 -> upc goes to 8.
3. DISP0 with op_idx=9 where dispatch0[9] is invalid -> upc=29 and trap=1 for exactly one cycle, 0 afterwards.
4. stall=1 for 3 cycles at upc=6 -> upc and ctrl unchanged, no trap, even when the word at upc dispatches to an invalid entry. Release -> advances next cycle.
5. At upc=3, write store[3] ctrl=15'h7FFF -> ctrl still old in the write cycle, 7FFF next cycle if stalled. Dispatch entry rewritten in its use cycle -> old target taken.
6. Assert reset mid-sequence with wr_en=1 -> upc=0, ctrl=0, trap=0; the write is dropped, and a prior dispatch hit now traps.
